// File: rtl/ulaplus_palette.sv
// ULAplus controller: register/data port decode, palette RAM, mode register
// and a registered video-side palette lookup.
//
// Ports:
//   clk28, rst          clock, asynchronous active-high reset
//   en                  feature enable; low clears mode and masks the ports
//   ioreq, rd, wr, a, d CPU I/O bus (strobes may span many clk28 cycles)
//   d_out, d_out_active read-back data and its bus-drive enable
//   active, grayscale   mode bits 0 and 1
//   write_req, write_addr  one-cycle pulse and index per palette write
//   pix_idx, pix_data   video lookup, one cycle latency
module ulaplus_palette #(
  parameter int          ENTRIES   = 64,
  parameter int          ENTRY_W   = 8,
  parameter int          AUTOINC   = 0,
  parameter logic [15:0] PORT_REG  = 16'hBF3B,
  parameter logic [15:0] PORT_DATA = 16'hFF3B
) (
  input  logic               clk28,
  input  logic               rst,
  input  logic               en,
  input  logic               ioreq,
  input  logic               rd,
  input  logic               wr,
  input  logic [15:0]        a,
  input  logic [7:0]         d,
  output logic [7:0]         d_out,
  output logic               d_out_active,
  output logic               active,
  output logic               grayscale,
  output logic               write_req,
  output logic [5:0]         write_addr,
  input  logic [5:0]         pix_idx,
  output logic [ENTRY_W-1:0] pix_data
);

  localparam logic [5:0] IMASK = 6'(ENTRIES - 1);

  logic       reg_cs;
  logic       dat_cs;
  logic       wr_reg_s;
  logic       wr_dat_s;
  logic       rd_reg_s;
  logic       rd_dat_s;
  logic       wr_reg_q;
  logic       wr_dat_q;
  logic       rd_dat_q;
  logic       wr_arm;
  logic       wr_reg_edge;
  logic       wr_dat_edge;
  logic       rd_dat_end;
  logic       grp00;
  logic       mode_sel;
  logic       pal_wr;
  logic [1:0] mode;
  logic [7:0] addr_reg;
  logic [5:0] idx;
  logic [5:0] nxt_idx;
  logic [7:0] data_val;

  // Sized to the full 6-bit index space; masked indices keep the
  // unused upper entries unreachable when ENTRIES < 64.
  logic [ENTRY_W-1:0] pal [64];

  assign reg_cs   = en & ioreq & (a == PORT_REG);
  assign dat_cs   = en & ioreq & (a == PORT_DATA);
  assign wr_reg_s = wr & reg_cs;
  assign wr_dat_s = wr & dat_cs;
  assign rd_reg_s = rd & reg_cs;
  assign rd_dat_s = rd & dat_cs;

  // wr_arm stays low after reset until wr has been seen low, so a strobe
  // still held across reset release cannot fake a rising edge.
  assign wr_reg_edge = wr_reg_s & ~wr_reg_q & wr_arm;
  assign wr_dat_edge = wr_dat_s & ~wr_dat_q & wr_arm;
  assign rd_dat_end  = rd_dat_q & ~rd_dat_s;

  assign idx      = addr_reg[5:0] & IMASK;
  assign nxt_idx  = (idx + 6'd1) & IMASK;
  assign grp00    = (addr_reg[7:6] == 2'b00);
  assign mode_sel = (addr_reg == 8'h40);
  assign pal_wr   = wr_dat_edge & grp00;

  assign active    = mode[0];
  assign grayscale = mode[1];

  always_comb begin
    data_val = 8'h00;
    if (grp00) begin
      data_val = 8'(pal[idx]);
    end else if (mode_sel) begin
      data_val = {6'b0, mode};
    end
  end

  always_ff @(posedge clk28) begin
    if (pal_wr) begin
      pal[idx] <= d[ENTRY_W-1:0];
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      wr_reg_q     <= 1'b0;
      wr_dat_q     <= 1'b0;
      rd_dat_q     <= 1'b0;
      wr_arm       <= 1'b0;
      mode         <= 2'b00;
      addr_reg     <= 8'h00;
      write_req    <= 1'b0;
      write_addr   <= 6'd0;
      d_out_active <= 1'b0;
      d_out        <= 8'h00;
      pix_data     <= '0;
    end else begin
      wr_reg_q <= wr_reg_s;
      wr_dat_q <= wr_dat_s;
      rd_dat_q <= rd_dat_s;
      wr_arm   <= wr_arm | ~wr;

      write_req <= pal_wr;
      if (pal_wr) begin
        write_addr <= idx;
      end

      if (!en) begin
        mode <= 2'b00;
      end else if (wr_dat_edge && mode_sel) begin
        mode <= d[1:0];
      end

      // A write uses the pre-increment idx; the increment lands together.
      if (wr_reg_edge) begin
        addr_reg <= d;
      end else if (AUTOINC != 0 && grp00 && (pal_wr || rd_dat_end)) begin
        addr_reg[5:0] <= nxt_idx;
      end

      d_out_active <= rd_reg_s | rd_dat_s;
      if (rd_reg_s) begin
        d_out <= addr_reg;
      end else if (rd_dat_s) begin
        d_out <= data_val;
      end else begin
        d_out <= 8'h00;
      end

      // Nonblocking read of pal gives read-before-write on a collision.
      pix_data <= pal[pix_idx & IMASK];
    end
  end

endmodule

// File: tb/tb_ulaplus_palette.sv
// Bench for ulaplus_palette: a default instance and a 16-entry
// auto-increment instance on a shared bus, checked against a model.
module tb_ulaplus_palette;

  localparam logic [15:0] PR = 16'hBF3B;
  localparam logic [15:0] PD = 16'hFF3B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en = 2'b11;
  logic        ioreq = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] a = 16'h0;
  logic [7:0]  d = 8'h0;
  logic [5:0]  pix_idx = 6'd0;

  logic [7:0] dout0, dout1;
  logic       doa0, doa1, act0, act1, gray0, gray1, wreq0, wreq1;
  logic [5:0] waddr0, waddr1;
  logic [7:0] pix0, pix1;

  int tests = 0;
  int fails = 0;

  int m_addr [2];
  int m_mode [2];
  int m_pal [2][64];
  int m_cnt [2];
  int m_waddr [2];
  int ents [2] = '{64, 16};
  int ainc [2] = '{0, 1};
  int o_cnt [2] = '{0, 0};
  int o_waddr [2] = '{0, 0};
  int rd_val [2];

  ulaplus_palette u0 (
    .clk28(clk), .rst(rst), .en(en[0]), .ioreq(ioreq), .rd(rd), .wr(wr),
    .a(a), .d(d), .d_out(dout0), .d_out_active(doa0), .active(act0),
    .grayscale(gray0), .write_req(wreq0), .write_addr(waddr0),
    .pix_idx(pix_idx), .pix_data(pix0)
  );

  ulaplus_palette #(.ENTRIES(16), .AUTOINC(1)) u1 (
    .clk28(clk), .rst(rst), .en(en[1]), .ioreq(ioreq), .rd(rd), .wr(wr),
    .a(a), .d(d), .d_out(dout1), .d_out_active(doa1), .active(act1),
    .grayscale(gray1), .write_req(wreq1), .write_addr(waddr1),
    .pix_idx(pix_idx), .pix_data(pix1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wreq0 === 1'b1) begin
      o_cnt[0]++;
      o_waddr[0] = int'(waddr0);
    end
    if (wreq1 === 1'b1) begin
      o_cnt[1]++;
      o_waddr[1] = int'(waddr1);
    end
  end

  function automatic logic [7:0] g_dout(int i);
    return (i == 0) ? dout0 : dout1;
  endfunction
  function automatic logic g_doa(int i);
    return (i == 0) ? doa0 : doa1;
  endfunction
  function automatic logic g_act(int i);
    return (i == 0) ? act0 : act1;
  endfunction
  function automatic logic g_gray(int i);
    return (i == 0) ? gray0 : gray1;
  endfunction
  function automatic logic [7:0] g_pix(int i);
    return (i == 0) ? pix0 : pix1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    ioreq = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    repeat (n) tick();
  endtask

  // Model: one access = one action, indices wrap modulo the entry count.
  function automatic void m_write(int i, logic [15:0] p, int v);
    int ix;
    if (!en[i]) return;
    if (p == PR) begin
      m_addr[i] = v;
      return;
    end
    ix = (m_addr[i] % 64) % ents[i];
    if (m_addr[i] < 64) begin
      m_pal[i][ix] = v;
      m_cnt[i]++;
      m_waddr[i] = ix;
      if (ainc[i] != 0) m_addr[i] = (ix + 1) % ents[i];
    end else if (m_addr[i] == 64) begin
      m_mode[i] = v % 4;
    end
  endfunction

  function automatic int m_read(int i, logic [15:0] p);
    if (p == PR) return m_addr[i];
    if (m_addr[i] < 64) return m_pal[i][(m_addr[i] % 64) % ents[i]];
    if (m_addr[i] == 64) return m_mode[i];
    return 0;
  endfunction

  function automatic void m_rdend(int i, logic [15:0] p);
    if (en[i] && p == PD && m_addr[i] < 64 && ainc[i] != 0)
      m_addr[i] = ((m_addr[i] % ents[i]) + 1) % ents[i];
  endfunction

  task automatic io_write(logic [15:0] p, logic [7:0] v, int hold);
    a = p;
    d = v;
    ioreq = 1'b1;
    wr = 1'b1;
    repeat (hold) tick();
    wr = 1'b0;
    ioreq = 1'b0;
    for (int i = 0; i < 2; i++) m_write(i, p, int'(v));
    idle(2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wcnt%0d", i), o_cnt[i], m_cnt[i]);
      if (m_cnt[i] > 0)
        chk($sformatf("waddr%0d", i), o_waddr[i], m_waddr[i]);
      chk($sformatf("active%0d", i), g_act(i), m_mode[i] % 2);
      chk($sformatf("gray%0d", i), g_gray(i), m_mode[i] / 2);
    end
  endtask

  task automatic io_read(logic [15:0] p, int hold);
    int ev [2];
    for (int i = 0; i < 2; i++) ev[i] = m_read(i, p);
    a = p;
    ioreq = 1'b1;
    rd = 1'b1;
    repeat (hold) tick();
    for (int i = 0; i < 2; i++) begin
      rd_val[i] = int'(g_dout(i));
      chk($sformatf("doa%0d", i), g_doa(i), en[i]);
      if (en[i]) chk($sformatf("dout%0d", i), g_dout(i), ev[i]);
    end
    rd = 1'b0;
    ioreq = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("doa_hold%0d", i), g_doa(i), en[i]);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("doa_drop%0d", i), g_doa(i), 1'b0);
      m_rdend(i, p);
    end
    idle(1);
  endtask

  task automatic pix_chk(logic [5:0] ix);
    pix_idx = ix;
    tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("pix%0d[%0d]", i, ix), g_pix(i),
          m_pal[i][int'(ix) % ents[i]]);
  endtask

  task automatic m_reset;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0;
      m_mode[i] = 0;
    end
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_waddr[i] = 0;
    end
    rst = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_dout%0d", i), g_dout(i), 8'h00);
      chk($sformatf("rst_doa%0d", i), g_doa(i), 1'b0);
      chk($sformatf("rst_act%0d", i), g_act(i), 1'b0);
      chk($sformatf("rst_gray%0d", i), g_gray(i), 1'b0);
      chk($sformatf("rst_pix%0d", i), g_pix(i), 8'h00);
    end
    chk("rst_wreq", {wreq0, wreq1}, 2'b00);
    chk("rst_waddr", {waddr0, waddr1}, 12'h000);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 64; k++) begin
      io_write(PR, 8'(k), 1);
      io_write(PD, 8'($urandom), 1);
    end

    // single pulse for a long strobe, then read-back
    io_write(PR, 8'h05, 1);
    io_write(PD, 8'hE3, 10);
    chk("long_waddr", o_waddr[0], 5);
    io_read(PD, 3);
    chk("rd_e3", rd_val[0], 8'hE3);

    // mode register and en drop
    io_write(PR, 8'h40, 1);
    io_write(PD, 8'h03, 1);
    chk("mode_on", {act0, gray0}, 2'b11);
    io_read(PD, 2);
    chk("rd_mode", rd_val[0], 8'h03);
    en = 2'b00;
    tick();
    m_mode[0] = 0;
    m_mode[1] = 0;
    chk("en_off_mode", {act0, gray0, act1, gray1}, 4'b0000);
    io_read(PD, 2);
    en = 2'b11;
    tick();

    // auto-increment wrap on the 16-entry instance
    io_write(PR, 8'h0F, 1);
    io_write(PD, 8'h11, 1);
    io_write(PD, 8'h22, 1);
    pix_chk(6'd15);
    chk("wrap15", pix1, 8'h11);
    pix_chk(6'd0);
    chk("wrap0", pix1, 8'h22);
    io_read(PR, 1);
    chk("wrap_addr", rd_val[1], 8'h01);

    // read-before-write on the video port
    io_write(PR, 8'h07, 1);
    io_write(PD, 8'h12, 1);
    io_write(PR, 8'h07, 1);
    pix_idx = 6'd7;
    tick();
    a = PD;
    d = 8'h55;
    ioreq = 1'b1;
    wr = 1'b1;
    tick();
    chk("rbw_old0", pix0, 8'h12);
    chk("rbw_old1", pix1, 8'h12);
    tick();
    chk("rbw_new0", pix0, 8'h55);
    chk("rbw_new1", pix1, 8'h55);
    wr = 1'b0;
    ioreq = 1'b0;
    for (int i = 0; i < 2; i++) m_write(i, PD, 8'h55);
    idle(2);

    // reset in the middle of a held write strobe
    io_write(PR, 8'h40, 1);
    io_write(PD, 8'h03, 1);
    io_write(PR, 8'h03, 1);
    a = PD;
    d = 8'h9C;
    ioreq = 1'b1;
    wr = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) m_write(i, PD, 8'h9C);
    rst = 1'b1;
    repeat (2) tick();
    m_reset();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_held_cnt0", o_cnt[0], m_cnt[0]);
    chk("rst_held_cnt1", o_cnt[1], m_cnt[1]);
    chk("rst_mode", {act0, gray0, act1, gray1}, 4'b0000);
    wr = 1'b0;
    tick();
    d = 8'h3A;
    wr = 1'b1;
    repeat (2) tick();
    wr = 1'b0;
    ioreq = 1'b0;
    for (int i = 0; i < 2; i++) m_write(i, PD, 8'h3A);
    idle(2);
    chk("rearm_cnt0", o_cnt[0], m_cnt[0]);
    chk("rearm_waddr0", o_waddr[0], 0);
    pix_chk(6'd3);
    chk("keep_pal", pix0, 8'h9C);
    io_read(PR, 1);
    chk("rst_addr", rd_val[0], 8'h00);

    // write to an unmapped group is ignored
    io_write(PR, 8'h80, 1);
    io_write(PD, 8'hAA, 2);
    io_read(PD, 2);
    chk("unmapped_rd", rd_val[0], 8'h00);

    for (int n = 0; n < 80; n++) begin
      int op;
      int h;
      logic [7:0] v;
      op = int'($urandom_range(0, 3));
      h = int'($urandom_range(1, 4));
      case (op)
        0: begin
          v = 8'($urandom_range(0, 63));
          if ($urandom_range(0, 4) == 0) v = 8'h40;
          if ($urandom_range(0, 6) == 0) v = 8'($urandom);
          io_write(PR, v, h);
        end
        1: io_write(PD, 8'($urandom), h);
        2: io_read(PD, h);
        default: io_read(PR, h);
      endcase
      pix_chk(6'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
